// File: rtl/paddle_input_cond.sv
// Input conditioning for the ping-pong controller: synchronise and debounce buttons and paddles,
// emit press/release pulses, and run a per-paddle swing/fault FSM. Define PADDLE_BTN_REPEAT_EN for button auto-repeat.
module paddle_input_cond #(
    parameter int N_BTN          = 5,
    parameter int DB_CYCLES      = 1000000,
    parameter int HOLD_TICKS     = 20,
    parameter int COOLDOWN_TICKS = 2,
    parameter int REPEAT_DELAY   = 50000000,
    parameter int REPEAT_PERIOD  = 10000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [1:0]       paddle_i,
    input  logic             tick_i,
    input  logic             game_en_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [1:0]       paddle_level_o,
    output logic [1:0]       swing_o,
    output logic [1:0]       hold_fault_o
);
    localparam int N_IN     = N_BTN + 2;
    localparam int DB_W     = $clog2(DB_CYCLES);
    localparam int TCNT_MAX = (HOLD_TICKS > COOLDOWN_TICKS) ?
                              ((HOLD_TICKS > 2) ? HOLD_TICKS : 2) :
                              ((COOLDOWN_TICKS > 2) ? COOLDOWN_TICKS : 2);
    localparam int T_W      = $clog2(TCNT_MAX);

    typedef enum logic [1:0] {P_IDLE, P_SWING, P_FAULT, P_COOL} pad_state_t;

    if (DB_CYCLES < 2) begin : g_chk_db
        $error("DB_CYCLES must be at least 2");
    end
    if (HOLD_TICKS < 1 || COOLDOWN_TICKS < 1) begin : g_chk_ticks
        $error("HOLD_TICKS and COOLDOWN_TICKS must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_rep
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [N_IN-1:0]  raw_in;
    logic [N_IN-1:0]  stable_vec;
    logic [N_IN-1:0]  rise;
    logic [N_IN-1:0]  fall;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;

    assign raw_in = {paddle_i, btn_i};

    genvar gi;
    for (gi = 0; gi < N_IN; gi++) begin : g_db
        logic            sync1_q;
        logic            sync2_q;
        logic            stable_q;
        logic [DB_W-1:0] cnt_q;
        logic            flip;

        assign flip           = (sync2_q != stable_q) && (cnt_q == DB_W'(DB_CYCLES - 1));
        assign rise[gi]       = flip & sync2_q;
        assign fall[gi]       = flip & ~sync2_q;
        assign stable_vec[gi] = stable_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync1_q <= raw_in[gi];
                sync2_q <= sync1_q;
                if (sync2_q == stable_q) begin
                    cnt_q <= '0;
                end else if (flip) begin
                    stable_q <= sync2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef PADDLE_BTN_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             ((REPEAT_DELAY > 2) ? REPEAT_DELAY : 2) :
                             ((REPEAT_PERIOD > 2) ? REPEAT_PERIOD : 2);
    localparam int REP_W   = $clog2(REP_MAX);

    logic [N_BTN-1:0] rep_fire;

    for (gi = 0; gi < N_BTN; gi++) begin : g_rep
        logic [REP_W-1:0] rep_cnt_q;
        logic             rep_armed_q;
        logic             held;

        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
        assign held         = stable_vec[gi] & ~fall[gi];
        assign rep_fire[gi] = held && (rep_armed_q ? (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1))
                                                   : (rep_cnt_q == REP_W'(REPEAT_DELAY - 1)));

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rep_cnt_q   <= '0;
                rep_armed_q <= 1'b0;
            end else if (!held) begin
                rep_cnt_q   <= '0;
                rep_armed_q <= 1'b0;
            end else if (rep_fire[gi]) begin
                rep_cnt_q   <= '0;
                rep_armed_q <= 1'b1;
            end else begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
`ifdef PADDLE_BTN_REPEAT_EN
            press_q   <= rise[N_BTN-1:0] | rep_fire;
`else
            press_q   <= rise[N_BTN-1:0];
`endif
            release_q <= fall[N_BTN-1:0];
        end
    end

    assign btn_level_o    = stable_vec[N_BTN-1:0];
    assign btn_press_o    = press_q;
    assign btn_release_o  = release_q;
    assign paddle_level_o = stable_vec[N_IN-1:N_BTN];

    // The FSM acts on debounced edges in the same cycle the level changes.
    for (gi = 0; gi < 2; gi++) begin : g_pad
        pad_state_t     state_q;
        logic [T_W-1:0] cnt_q;
        logic           swing_q;
        logic           fault_q;
        logic           p_rise;
        logic           p_fall;

        assign p_rise           = rise[N_BTN+gi];
        assign p_fall           = fall[N_BTN+gi];
        assign swing_o[gi]      = swing_q;
        assign hold_fault_o[gi] = fault_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= P_IDLE;
                cnt_q   <= '0;
                swing_q <= 1'b0;
                fault_q <= 1'b0;
            end else begin
                swing_q <= 1'b0;
                if (!game_en_i) begin
                    state_q <= P_IDLE;
                    cnt_q   <= '0;
                    fault_q <= 1'b0;
                end else begin
                    case (state_q)
                        P_IDLE: begin
                            if (p_rise) begin
                                state_q <= P_SWING;
                                cnt_q   <= '0;
                                swing_q <= 1'b1;
                            end
                        end
                        P_SWING: begin
                            if (p_fall) begin
                                state_q <= P_COOL;
                                cnt_q   <= '0;
                            end else if (tick_i) begin
                                if (cnt_q == T_W'(HOLD_TICKS - 1)) begin
                                    state_q <= P_FAULT;
                                    fault_q <= 1'b1;
                                end else begin
                                    cnt_q <= cnt_q + 1'b1;
                                end
                            end
                        end
                        P_FAULT: begin
                            if (p_fall) begin
                                state_q <= P_COOL;
                                cnt_q   <= '0;
                                fault_q <= 1'b0;
                            end
                        end
                        P_COOL: begin
                            if (p_rise) begin
                                state_q <= P_FAULT;
                                fault_q <= 1'b1;
                            end else if (tick_i) begin
                                if (cnt_q == T_W'(COOLDOWN_TICKS - 1)) begin
                                    state_q <= P_IDLE;
                                end else begin
                                    cnt_q <= cnt_q + 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_q <= P_IDLE;
                            fault_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_input_cond.sv
// Testbench for paddle_input_cond: directed scenarios plus random stimulus against a behavioural model.
module tb_paddle_input_cond;
    localparam int N_BTN   = 5;
    localparam int DB      = 4;
    localparam int HOLD    = 3;
    localparam int COOLT   = 2;
    localparam int RDELAY  = 20;
    localparam int RPERIOD = 5;
    localparam int N_IN    = N_BTN + 2;
    localparam int M_IDLE  = 0;
    localparam int M_SWING = 1;
    localparam int M_FAULT = 2;
    localparam int M_COOL  = 3;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic [N_BTN-1:0] btn_i = '0;
    logic [1:0]       paddle_i = '0;
    logic             tick_i = 1'b0;
    logic             game_en_i = 1'b0;
    logic [N_BTN-1:0] btn_level_o;
    logic [N_BTN-1:0] btn_press_o;
    logic [N_BTN-1:0] btn_release_o;
    logic [1:0]       paddle_level_o;
    logic [1:0]       swing_o;
    logic [1:0]       hold_fault_o;

    always #5 clk = ~clk;

    paddle_input_cond #(
        .N_BTN(N_BTN), .DB_CYCLES(DB), .HOLD_TICKS(HOLD), .COOLDOWN_TICKS(COOLT),
        .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .clk(clk), .resetn(resetn), .btn_i(btn_i), .paddle_i(paddle_i),
        .tick_i(tick_i), .game_en_i(game_en_i),
        .btn_level_o(btn_level_o), .btn_press_o(btn_press_o), .btn_release_o(btn_release_o),
        .paddle_level_o(paddle_level_o), .swing_o(swing_o), .hold_fault_o(hold_fault_o)
    );

    wire  [3*N_BTN+5:0] obs = {btn_level_o, btn_press_o, btn_release_o, paddle_level_o, swing_o, hold_fault_o};
    logic [3*N_BTN+5:0] exp_vec;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: a level flips once the twice-delayed input has disagreed with it for DB samples.
    logic [31:0]      m_hist [N_IN];
    logic [N_IN-1:0]  m_lvl, m_rise, m_fall;
    logic [N_BTN-1:0] m_press;
    int               m_since [N_BTN];
    int               m_mode [2];
    int               m_ticks [2];
    logic [1:0]       m_swing, m_fault;

    task automatic model_reset();
        for (int i = 0; i < N_IN; i++) m_hist[i] = '0;
        for (int b = 0; b < N_BTN; b++) m_since[b] = 0;
        for (int p = 0; p < 2; p++) begin
            m_mode[p]  = M_IDLE;
            m_ticks[p] = 0;
        end
        m_lvl = '0; m_rise = '0; m_fall = '0; m_press = '0; m_swing = '0; m_fault = '0;
        exp_vec = '0;
    endtask

    task automatic step(input bit tk);
        logic [N_IN-1:0] r;
        bit ge;
        bit agree;
        tick_i = tk;
        r  = {paddle_i, btn_i};
        ge = game_en_i;
        @(posedge clk);
        for (int i = 0; i < N_IN; i++) begin
            m_hist[i] = {m_hist[i][30:0], r[i]};
            agree = 1'b1;
            for (int k = 2; k < DB + 2; k++) if (m_hist[i][k] == m_lvl[i]) agree = 1'b0;
            m_rise[i] = agree & ~m_lvl[i];
            m_fall[i] = agree & m_lvl[i];
            if (agree) m_lvl[i] = ~m_lvl[i];
        end
        for (int b = 0; b < N_BTN; b++) begin
            m_press[b] = m_rise[b];
`ifdef PADDLE_BTN_REPEAT_EN
            if (m_rise[b]) m_since[b] = 0;
            else if (m_lvl[b]) begin
                m_since[b]++;
                if (m_since[b] == RDELAY || (m_since[b] > RDELAY && (m_since[b] - RDELAY) % RPERIOD == 0))
                    m_press[b] = 1'b1;
            end
`endif
        end
        m_swing = '0;
        for (int p = 0; p < 2; p++) begin
            if (!ge) begin
                m_mode[p]  = M_IDLE;
                m_ticks[p] = 0;
            end else if (m_mode[p] == M_IDLE) begin
                if (m_rise[N_BTN+p]) begin m_mode[p] = M_SWING; m_ticks[p] = 0; m_swing[p] = 1'b1; end
            end else if (m_mode[p] == M_SWING) begin
                if (m_fall[N_BTN+p]) begin m_mode[p] = M_COOL; m_ticks[p] = 0; end
                else if (tk) begin
                    m_ticks[p]++;
                    if (m_ticks[p] == HOLD) m_mode[p] = M_FAULT;
                end
            end else if (m_mode[p] == M_FAULT) begin
                if (m_fall[N_BTN+p]) begin m_mode[p] = M_COOL; m_ticks[p] = 0; end
            end else begin
                if (m_rise[N_BTN+p]) m_mode[p] = M_FAULT;
                else if (tk) begin
                    m_ticks[p]++;
                    if (m_ticks[p] == COOLT) m_mode[p] = M_IDLE;
                end
            end
            m_fault[p] = (m_mode[p] == M_FAULT);
        end
        #1;
        exp_vec = {m_lvl[N_BTN-1:0], m_press, m_fall[N_BTN-1:0], m_lvl[N_IN-1:N_BTN], m_swing, m_fault};
        cyc++;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL reset_async got=%h want=%h", obs, '0); end
        @(posedge clk);
        #2 resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
        end
    endtask

    task automatic test_btn_debounce();
        btn_i[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0);
            checks += 2;
            if (obs !== exp_vec) begin failures++; $display("FAIL debounce_rise cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
            if (btn_press_o[2] !== (k == 6) || btn_level_o[2] !== (k >= 6)) begin
                failures++; $display("FAIL press_timing edge=%0d press=%b level=%b", k, btn_press_o[2], btn_level_o[2]);
            end
        end
        btn_i[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0);
            checks += 2;
            if (obs !== exp_vec) begin failures++; $display("FAIL debounce_fall cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
            if (btn_release_o[2] !== (k == 6)) begin
                failures++; $display("FAIL release_timing edge=%0d release=%b want=%b", k, btn_release_o[2], (k == 6));
            end
        end
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 14; c++) begin
            btn_i[3] = (c < 3);
            step(1'b0);
            checks += 2;
            if (obs !== exp_vec) begin failures++; $display("FAIL glitch_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
            if ({btn_level_o[3], btn_press_o[3], btn_release_o[3]} !== 3'b000) begin
                failures++; $display("FAIL glitch_quiet c=%0d got=%b want=000", c, {btn_level_o[3], btn_press_o[3], btn_release_o[3]});
            end
        end
    endtask

    task automatic test_paddle_swing();
        int nsw;
        nsw = 0;
        game_en_i = 1'b1;
        for (int c = 0; c < 52; c++) begin
            paddle_i[0] = (c < 14) || (c >= 30 && c < 38);
            step(c == 10 || c == 12 || c == 22 || c == 24 || c == 46 || c == 48);
            checks += 2;
            if (obs !== exp_vec) begin failures++; $display("FAIL swing_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
            if (hold_fault_o[0] !== 1'b0) begin failures++; $display("FAIL swing_nofault c=%0d got=%b want=0", c, hold_fault_o[0]); end
            if (swing_o[0] === 1'b1) nsw++;
        end
        checks++;
        if (nsw != 2) begin failures++; $display("FAIL swing_count got=%0d want=2", nsw); end
    endtask

    task automatic test_paddle_hold();
        int nsw;
        nsw = 0;
        for (int c = 0; c < 35; c++) begin
            paddle_i[1] = (c < 20);
            step(c == 8 || c == 10 || c == 12 || c == 28 || c == 30);
            checks += 2;
            if (obs !== exp_vec) begin failures++; $display("FAIL hold_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
            if (hold_fault_o[1] !== (c >= 12 && c < 25)) begin
                failures++; $display("FAIL hold_fault c=%0d got=%b want=%b", c, hold_fault_o[1], (c >= 12 && c < 25));
            end
            if (swing_o[1] === 1'b1) nsw++;
        end
        checks++;
        if (nsw != 1) begin failures++; $display("FAIL hold_swing_count got=%0d want=1", nsw); end
    endtask

    task automatic test_cooldown_repress();
        int nsw;
        nsw = 0;
        for (int c = 0; c < 50; c++) begin
            paddle_i[0] = (c < 8) || (c >= 16 && c < 40);
            game_en_i   = (c != 30);
            step(c == 15);
            checks += 2;
            if (obs !== exp_vec) begin failures++; $display("FAIL cool_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
            if (hold_fault_o[0] !== (c >= 21 && c < 30)) begin
                failures++; $display("FAIL cool_fault c=%0d got=%b want=%b", c, hold_fault_o[0], (c >= 21 && c < 30));
            end
            if (swing_o[0] === 1'b1) nsw++;
        end
        checks++;
        if (nsw != 1) begin failures++; $display("FAIL cool_swing_count got=%0d want=1", nsw); end
    endtask

    task automatic test_reset_mid_swing();
        paddle_i[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL midrst_pre cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
        end
        #2 resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL midrst_async got=%h want=%h", obs, '0); end
        paddle_i = '0;
        @(posedge clk);
        #2 resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL midrst_post cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
        end
    endtask

`ifdef PADDLE_BTN_REPEAT_EN
    task automatic test_repeat();
        int first;
        int npress;
        first = -1;
        npress = 0;
        for (int c = 0; c < 68; c++) begin
            btn_i[2] = (c < 60);
            step(1'b0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL repeat_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
            if (btn_press_o[2] === 1'b1) begin
                if (first < 0) first = c;
                if (c - first < 40) npress++;
            end
        end
        checks++;
        if (npress != 5) begin failures++; $display("FAIL repeat_count got=%0d want=5", npress); end
    endtask
`endif

    task automatic test_random();
        game_en_i = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_BTN; b++) if ($urandom_range(9) == 0) btn_i[b] = ~btn_i[b];
            for (int p = 0; p < 2; p++) if ($urandom_range(11) == 0) paddle_i[p] = ~paddle_i[p];
            if ($urandom_range(199) == 0) game_en_i = ~game_en_i;
            step($urandom_range(3) == 0);
            checks++;
            if (obs !== exp_vec) begin failures++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_btn_debounce();
        test_glitch();
        test_paddle_swing();
        test_paddle_hold();
        test_cooldown_repress();
        test_reset_mid_swing();
`ifdef PADDLE_BTN_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d limit=100000", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
